// File: rtl/d_mem_arbiter_if.sv
// Bundle for the data-memory arbiter: two requester ports plus the memory side.
// The arbiter uses the slave modport; requesters and memory use the master modport.
interface d_mem_arbiter_if #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int BLW = 4
);
  logic           a_req;
  logic [AW-1:0]  a_addr;
  logic           a_we;
  logic [DW-1:0]  a_wdata;
  logic           a_ack;
  logic [DW-1:0]  a_rdata;

  logic           b_req;
  logic [AW-1:0]  b_addr;
  logic           b_we;
  logic [DW-1:0]  b_wdata;
  logic [BLW-1:0] b_blen;
  logic           b_ack;
  logic           b_last;
  logic [DW-1:0]  b_rdata;

  logic [AW-1:0]  mem_addr;
  logic           mem_we;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;

  logic           busy;

  modport slave (
    input  a_req, a_addr, a_we, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_addr, b_we, b_wdata, b_blen,
    output b_ack, b_last, b_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output a_req, a_addr, a_we, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_addr, b_we, b_wdata, b_blen,
    input  b_ack, b_last, b_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/d_mem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU (A)
// and the DMA/debug engine (B); B may read bursts with auto-incrementing address.
//
//   state | meaning
//   IDLE  | no access in flight; sample eligible requests and grant one
//   ACC_A | port A single access presented to memory
//   ACC_B | port B access presented to memory; stays here for burst beats
module d_mem_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int BLW = 4
) (
  input  logic           clk,
  input  logic           rst,
  d_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_A = 2'd1,
    ACC_B = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            a_ack_q, a_ack_d;
  logic [DW-1:0]   a_rdata_q, a_rdata_d;
  logic            b_ack_q, b_ack_d;
  logic            b_last_q, b_last_d;
  logic [DW-1:0]   b_rdata_q, b_rdata_d;
  logic [BLW-1:0]  beat_cnt_q, beat_cnt_d;
  logic            prio_b_q, prio_b_d;

  logic a_elig, b_elig, grant_a, grant_b;

  // A port whose ack is showing is still holding req from the finished access.
  assign a_elig  = bus.a_req && !a_ack_q;
  assign b_elig  = bus.b_req && !b_ack_q;
  assign grant_a = a_elig && (!b_elig || !prio_b_q);
  assign grant_b = b_elig && !grant_a;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    a_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_ack_d     = 1'b0;
    b_last_d    = 1'b0;
    b_rdata_d   = b_rdata_q;
    beat_cnt_d  = beat_cnt_q;
    prio_b_d    = prio_b_q;

    unique case (state_q)
      IDLE: begin
        if (grant_a) begin
          state_d     = ACC_A;
          mem_addr_d  = bus.a_addr;
          mem_we_d    = bus.a_we;
          mem_wdata_d = bus.a_wdata;
          prio_b_d    = 1'b1;
        end else if (grant_b) begin
          state_d     = ACC_B;
          mem_addr_d  = bus.b_addr;
          mem_we_d    = bus.b_we;
          mem_wdata_d = bus.b_wdata;
          beat_cnt_d  = bus.b_we ? '0 : bus.b_blen;
          prio_b_d    = 1'b0;
        end
      end

      ACC_A: begin
        if (!mem_we_q) a_rdata_d = bus.mem_rdata;
        a_ack_d = 1'b1;
        state_d = IDLE;
      end

      ACC_B: begin
        b_ack_d = 1'b1;
        if (!mem_we_q) begin
          b_rdata_d  = bus.mem_rdata;
          mem_addr_d = mem_addr_q + AW'(1);
        end
        // Down-counter reaching zero marks the final beat.
        if (beat_cnt_q == '0) begin
          b_last_d = 1'b1;
          state_d  = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q - BLW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_ack_q     <= 1'b0;
      b_last_q    <= 1'b0;
      b_rdata_q   <= '0;
      beat_cnt_q  <= '0;
      prio_b_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      a_ack_q     <= a_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_ack_q     <= b_ack_d;
      b_last_q    <= b_last_d;
      b_rdata_q   <= b_rdata_d;
      beat_cnt_q  <= beat_cnt_d;
      prio_b_q    <= prio_b_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.b_last    = b_last_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter with a behavioural 256x16 memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_d_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  d_mem_arbiter_if #(.AW(8), .DW(16), .BLW(4)) bus ();

  d_mem_arbiter #(.AW(8), .DW(16), .BLW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_addr = 8'h00; bus.a_we = 1'b0; bus.a_wdata = 16'h0000;
    bus.b_req = 1'b0; bus.b_addr = 8'h00; bus.b_we = 1'b0; bus.b_wdata = 16'h0000;
    bus.b_blen = 4'h0;
  endtask

  // One port A access; lat is the number of falling edges to a_ack, -1 on timeout.
  task automatic a_access(input logic [7:0] addr, input logic we, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd, output int wec);
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_addr = addr; bus.a_we = we; bus.a_wdata = wd;
    lat = -1; wec = 0; rd = 16'h0000;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.mem_we) wec++;
      if (bus.a_ack) begin
        lat = i; rd = bus.a_rdata;
        break;
      end
    end
    bus.a_req = 1'b0;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [15:0] wd);
    int lat, wec;
    logic [15:0] rd;
    a_access(addr, 1'b1, wd, lat, rd, wec);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL preload_lat[%h]: got %0d want 2", addr, lat); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.mem_we !== 1'b0)     begin bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0 || bus.b_last !== 1'b0)
      begin bad++; $display("FAIL rst_acks: got a=%b b=%b last=%b want 0", bus.a_ack, bus.b_ack, bus.b_last); end
    total++; if (bus.mem_addr !== 8'h00)  begin bad++; $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); end
    total++; if (bus.a_rdata !== 16'h0000 || bus.b_rdata !== 16'h0000)
      begin bad++; $display("FAIL rst_rdata: got a=%h b=%h want 0000", bus.a_rdata, bus.b_rdata); end
  endtask

  task automatic test_a_write_read();
    int lat, wec;
    logic [15:0] rd;
    a_access(8'h10, 1'b1, 16'h00AB, lat, rd, wec);
    total++; if (lat !== 2) begin bad++; $display("FAIL a_wr_lat: got %0d want 2", lat); end
    total++; if (wec !== 1) begin bad++; $display("FAIL a_wr_we_cycles: got %0d want 1", wec); end
    a_access(8'h10, 1'b0, 16'h0000, lat, rd, wec);
    total++; if (lat !== 2)        begin bad++; $display("FAIL a_rd_lat: got %0d want 2", lat); end
    total++; if (rd !== 16'h00AB)  begin bad++; $display("FAIL a_rd_data: got %h want 00ab", rd); end
    total++; if (wec !== 0)        begin bad++; $display("FAIL a_rd_we_cycles: got %0d want 0", wec); end
  endtask

  task automatic test_simultaneous();
    logic [5:0] aseq, bseq;
    logic [7:0] addr1, addr3, addr5;
    logic [15:0] ard, brd;
    logic blast;
    preload(8'h01, 16'h0101);
    preload(8'h02, 16'h0202);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 8'h01; bus.a_we = 1'b0;
    bus.b_req = 1'b1; bus.b_addr = 8'h02; bus.b_we = 1'b0; bus.b_blen = 4'h0;
    aseq = '0; bseq = '0; addr1 = '0; addr3 = '0; addr5 = '0; ard = '0; brd = '0; blast = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      aseq[k-1] = bus.a_ack;
      bseq[k-1] = bus.b_ack;
      if (k == 1) addr1 = bus.mem_addr;
      if (k == 3) addr3 = bus.mem_addr;
      if (k == 5) addr5 = bus.mem_addr;
      if (k == 4) begin brd = bus.b_rdata; blast = bus.b_last; end
      if (k == 6) ard = bus.a_rdata;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    total++; if (aseq !== 6'b100010) begin bad++; $display("FAIL sim_a_ack_seq: got %b want 100010", aseq); end
    total++; if (bseq !== 6'b001000) begin bad++; $display("FAIL sim_b_ack_seq: got %b want 001000", bseq); end
    total++; if (addr1 !== 8'h01 || addr3 !== 8'h02 || addr5 !== 8'h01)
      begin bad++; $display("FAIL sim_grant_addr: got %h %h %h want 01 02 01", addr1, addr3, addr5); end
    total++; if (brd !== 16'h0202 || blast !== 1'b1)
      begin bad++; $display("FAIL sim_b_data: got %h last=%b want 0202 last=1", brd, blast); end
    total++; if (ard !== 16'h0101) begin bad++; $display("FAIL sim_a_data: got %h want 0101", ard); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_burst_wrap();
    logic [15:0] vals [4];
    logic [3:0] lst;
    int n, first, lastk, stray;
    logic [15:0] exp_v [4];
    exp_v[0] = 16'h1111; exp_v[1] = 16'h2222; exp_v[2] = 16'h3333; exp_v[3] = 16'h4444;
    preload(8'hFE, 16'h1111);
    preload(8'hFF, 16'h2222);
    preload(8'h00, 16'h3333);
    preload(8'h01, 16'h4444);
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_addr = 8'hFE; bus.b_we = 1'b0; bus.b_blen = 4'd3;
    n = 0; first = -1; lastk = -1; lst = '0; stray = 0;
    for (int i = 0; i < 4; i++) vals[i] = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.b_ack) begin
        if (n < 4) begin vals[n] = bus.b_rdata; lst[n] = bus.b_last; end
        if (first < 0) first = k;
        n++;
        if (bus.b_last) begin lastk = k; break; end
      end
    end
    bus.b_req = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.b_ack) stray++; end
    total++; if (n !== 4)      begin bad++; $display("FAIL burst_beats: got %0d want 4", n); end
    total++; if (first !== 2 || lastk !== 5)
      begin bad++; $display("FAIL burst_timing: got first=%0d last=%0d want 2 5", first, lastk); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (vals[i] !== exp_v[i]) begin bad++; $display("FAIL burst_data[%0d]: got %h want %h", i, vals[i], exp_v[i]); end
    end
    total++; if (lst !== 4'b1000) begin bad++; $display("FAIL burst_last: got %b want 1000", lst); end
    total++; if (stray !== 0)     begin bad++; $display("FAIL burst_stray_ack: got %0d want 0", stray); end
  endtask

  task automatic test_a_blocked();
    int nb, lastk, ak, busy_err;
    logic [15:0] ard;
    for (int i = 0; i < 16; i++) preload(8'h40 + 8'(i), 16'h5000 + 16'(i));
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_addr = 8'h40; bus.b_we = 1'b0; bus.b_blen = 4'hF;
    nb = 0; lastk = -1; ak = -1; busy_err = 0; ard = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.a_req = 1'b1; bus.a_addr = 8'h10; bus.a_we = 1'b0; end
      if (lastk < 0 && !(bus.b_ack && bus.b_last) && !bus.busy) busy_err++;
      if (bus.b_ack) begin
        total++;
        if (bus.b_rdata !== 16'h5000 + 16'(nb))
          begin bad++; $display("FAIL blk_b_data[%0d]: got %h want %h", nb, bus.b_rdata, 16'h5000 + 16'(nb)); end
        nb++;
        if (bus.b_last) begin lastk = k; bus.b_req = 1'b0; end
      end
      if (bus.a_ack) begin ak = k; ard = bus.a_rdata; break; end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    total++; if (nb !== 16)       begin bad++; $display("FAIL blk_beats: got %0d want 16", nb); end
    total++; if (lastk !== 17)    begin bad++; $display("FAIL blk_last_cycle: got %0d want 17", lastk); end
    total++; if (ak !== 19)       begin bad++; $display("FAIL blk_a_ack_cycle: got %0d want 19", ak); end
    total++; if (ard !== 16'h00AB) begin bad++; $display("FAIL blk_a_data: got %h want 00ab", ard); end
    total++; if (busy_err !== 0)  begin bad++; $display("FAIL blk_busy: got %0d idle cycles want 0", busy_err); end
    @(negedge clk);
  endtask

  task automatic test_b_write();
    int wec, nack, nlast, ak, lat, w2;
    logic [15:0] rd;
    preload(8'h21, 16'h7777);
    preload(8'h20, 16'h0000);
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_addr = 8'h20; bus.b_we = 1'b1; bus.b_wdata = 16'h3C00; bus.b_blen = 4'd7;
    wec = 0; nack = 0; nlast = 0; ak = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.mem_we) wec++;
      if (bus.b_ack) begin
        nack++;
        if (bus.b_last) nlast++;
        if (nack == 1) ak = k;
        bus.b_req = 1'b0;
      end
    end
    bus.b_we = 1'b0;
    total++; if (wec !== 1)   begin bad++; $display("FAIL bwr_we_cycles: got %0d want 1", wec); end
    total++; if (nack !== 1)  begin bad++; $display("FAIL bwr_acks: got %0d want 1", nack); end
    total++; if (nlast !== 1) begin bad++; $display("FAIL bwr_last: got %0d want 1", nlast); end
    total++; if (ak !== 2)    begin bad++; $display("FAIL bwr_ack_cycle: got %0d want 2", ak); end
    a_access(8'h20, 1'b0, 16'h0000, lat, rd, w2);
    total++; if (rd !== 16'h3C00) begin bad++; $display("FAIL bwr_mem20: got %h want 3c00", rd); end
    a_access(8'h21, 1'b0, 16'h0000, lat, rd, w2);
    total++; if (rd !== 16'h7777) begin bad++; $display("FAIL bwr_mem21: got %h want 7777", rd); end
  endtask

  task automatic test_reset_mid_burst();
    int nb, stray, lat, wec;
    logic [15:0] rd;
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_addr = 8'h40; bus.b_we = 1'b0; bus.b_blen = 4'hF;
    nb = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.b_ack) nb++;
      if (nb == 3) break;
    end
    total++; if (nb !== 3) begin bad++; $display("FAIL rmb_start_beats: got %0d want 3", nb); end
    rst = 1'b1; bus.b_req = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0 || bus.b_ack !== 1'b0 || bus.busy !== 1'b0)
      begin bad++; $display("FAIL rmb_in_reset: got we=%b back=%b busy=%b want 0", bus.mem_we, bus.b_ack, bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0 || bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0 || bus.busy !== 1'b0)
      begin bad++; $display("FAIL rmb_after: got we=%b aack=%b back=%b busy=%b want 0", bus.mem_we, bus.a_ack, bus.b_ack, bus.busy); end
    stray = 0;
    repeat (20) begin @(negedge clk); if (bus.b_ack) stray++; end
    total++; if (stray !== 0) begin bad++; $display("FAIL rmb_stray_ack: got %0d want 0", stray); end
    a_access(8'h10, 1'b0, 16'h0000, lat, rd, wec);
    total++; if (lat !== 2 || rd !== 16'h00AB)
      begin bad++; $display("FAIL rmb_mem_kept: got lat=%0d data=%h want 2 00ab", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_a_write_read();
    test_simultaneous();
    test_burst_wrap();
    test_a_blocked();
    test_b_write();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_mem_arbiter.md
Name: d_mem_arbiter

Overview:
- Shares the single-port 256x16 data memory between two requesters: port A (CPU load/store) and port B (DMA/debug engine).
- Arbitration is round-robin with registered memory-side signals.
- Port B may issue read bursts of 1–16 words with an auto-incrementing address.
- Sits between the requesters and the data memory. The memory has a combinational read and commits writes at the clock edge when its write enable is high.

Parameters:
- AW, 8, address width (memory depth 2^AW).
- DW, 16, data width.
- BLW, 4, burst-length field width (max burst 2^BLW words).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- a_req  in  1  port A request; hold with a_addr/a_we/a_wdata stable until a_ack
- a_addr  in  AW  port A address
- a_we  in  1  port A write (1) / read (0)
- a_wdata  in  DW  port A write data
- a_ack  out  1  one-cycle pulse: access done; a_rdata valid this cycle
- a_rdata  out  DW  port A read data, held until next port A read
- b_req  in  1  port B request; hold stable until final b_ack (b_last)
- b_addr  in  AW  port B start address
- b_we  in  1  port B write (single beat only)
- b_wdata  in  DW  port B write data
- b_blen  in  BLW  burst length minus 1 (reads only)
- b_ack  out  1  per-beat pulse; b_rdata valid this cycle
- b_last  out  1  high with b_ack on final beat
- b_rdata  out  DW  port B read data
- mem_addr  out  AW  to memory address
- mem_we  out  1  to memory write enable
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  from memory read data (combinational)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high: rst sampled at posedge clk.
- Reset values: all outputs 0; state IDLE; round-robin pointer set so port A wins the first tie.
- States: IDLE, ACC_A, ACC_B.
- IDLE transitions at posedge:
  - Eligible requests are sampled; a port is not eligible in the cycle its own ack is high.
  - If only one is eligible, go to that port's ACC state.
  - If both, grant the port not served most recently, then toggle the pointer.
  - On entering ACC state, register mem_addr, mem_we and mem_wdata from the granted port. mem_we is 0 otherwise.
- ACC_A (one cycle):
  - At the next edge the memory commits the write; if a_we=0, latch mem_rdata into a_rdata.
  - Assert a_ack for the following cycle and return to IDLE (mem_we cleared).
- ACC_B, write or b_blen=0: same as ACC_A on port B; b_last=1 with b_ack. b_blen is ignored for writes.
- ACC_B, read burst of N=b_blen+1 beats:
  - The beat counter is loaded at grant.
  - Each edge: latch mem_rdata into b_rdata, pulse b_ack next cycle, increment mem_addr modulo 2^AW (8'hFF -> 8'h00).
  - b_acks arrive on N consecutive cycles; b_last accompanies the Nth.
  - The burst is never pre-empted. Port A waits; worst-case port A wait is 16 access cycles + 1.
- Latency: request sampled at edge E0 -> access cycle -> ack high in the cycle after E1. Best-case 2 cycles, single beat; throughput 1 access per 2 cycles per port.
- Write data is taken from the registered a_wdata or b_wdata at grant. Requester changes after grant do not affect the access in flight.
- Dropping req before ack is a protocol violation. The in-flight access still completes and is acked.
- Reset mid-access:
  - mem_we is forced 0 at the reset edge.
  - No ack is produced and burst state is discarded.
  - Memory contents are untouched by the arbiter.
- Both reqs high continuously: grants alternate A, B, A, B, ...

Test Plan:
- Reset: hold rst 2 cycles mid-burst -> mem_we=0, a_ack=b_ack=0, busy=0 in the cycle after release; no further b_ack.
- Port A write then read: write 16'h00AB to 8'h10, then read 8'h10 -> a_ack 2 cycles after each request; a_rdata=16'h00AB; mem_we high exactly one cycle.
- Simultaneous single requests: a_req and b_req both high at the first edge after reset, A reading 8'h01, B reading 8'h02 -> A served first, B next; with both held continuously, grants alternate A, B, A.
- Burst with wrap: preload 8'hFE=16'h1111, 8'hFF=16'h2222, 8'h00=16'h3333, 8'h01=16'h4444; B reads from 8'hFE with b_blen=3 -> four consecutive b_ack with those values; b_last on the 4th only.
- A blocked by burst: A requests during a b_blen=15 burst -> no a_ack until after B's last beat; A served immediately after and busy stays high throughout.
- B write ignores blen: b_we=1, b_blen=7, addr 8'h20, data 16'h3C00 -> exactly one mem_we pulse, one b_ack with b_last=1, and memory 8'h21 unchanged.
